fa_serial_arbiter: RTL and testbench
====================================

Name: fa_serial_arbiter

Overview:
Time-shares one techlib FA cell, used bit-serially, among NREQ requesters that each need a WIDTH-bit add.
- Round-robin arbitration picks one requester.
- The block captures that requester's operands and sequences the FA for WIDTH cycles, carry held in a flop.
- It then returns the sum and carry-out with a one-cycle DONE strobe.
- Sits between small datapath clients and the single shared adder resource.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, operand width in bits (2..32)

Ports:
C  input  1  clock, rising edge
R_N  input  1  asynchronous active-low reset
REQ  input  NREQ  request per client; held high until ACK
A_IN  input  NREQ*WIDTH  operand A, client i at [i*WIDTH +: WIDTH]
B_IN  input  NREQ*WIDTH  operand B, same packing
CI_IN  input  NREQ  carry-in per client
ACK  output  NREQ  one-hot, 1-cycle pulse: operands captured
GNT  output  NREQ  one-hot owner of the adder, from ACK cycle through DONE cycle
DONE  output  NREQ  one-hot, 1-cycle pulse: SUM/CO valid for that client
SUM  output  WIDTH  result; holds last value until next DONE
CO  output  1  carry-out of last operation; holds like SUM
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset (R_N low, any time): state=IDLE; ACK, GNT, DONE, SUM, CO, BUSY = 0; RR pointer = NREQ-1, so client 0 has top priority.
- Reset mid-operation: abort silently. No DONE is issued and the operation is lost.
- States:
  - IDLE -> RUN. Leave IDLE at an edge where any REQ bit is high. Winner w = first set REQ bit searching upward from ptr+1, modulo NREQ. Capture A_IN[w], B_IN[w] into shift registers, carry flop <= CI_IN[w], bit counter <= 0. ACK[w] and GNT[w] go high after this edge.
  - RUN -> RUN / DONE. Each cycle: FA(A=a_sr[0], B=b_sr[0], CI=carry). Result bit shifts into sum_sr MSB; a_sr and b_sr shift right; carry <= FA.CO; counter++. After WIDTH RUN cycles, go to DONE.
  - DONE -> IDLE. SUM <= sum_sr, CO <= carry, DONE[w]=1 for one cycle, ptr <= w. Next edge returns to IDLE.
- Latency: REQ sampled at edge t; ACK visible t+1; DONE visible t+WIDTH+1. Throughput is one op per WIDTH+2 cycles.
- REQ changes during RUN/DONE are ignored. A REQ dropped before ACK is a withdrawal and is legal.
- Operands must be stable only at the capture edge.
- The counter is $clog2(WIDTH)+1 bits wide, with no wrap hazard.
- The FA result wraps modulo 2^WIDTH. CO reports the carry out of bit WIDTH-1.
- Simultaneous requests: exactly one ACK per grant, and fairness is strict round-robin.
- DONE cycle and a new REQ: the next grant is taken only from IDLE. No back-to-back grant out of DONE.

Optional Feature:
FA_SERIAL_OVF_EN
- Defined: adds output OVF (1 bit), signed two's-complement overflow = carry into bit WIDTH-1 XOR CO. It is captured at DONE, held like SUM, and reset to 0.
- Not defined: the OVF port and its flop are absent; all other behaviour is identical.

Decomposition:
- Package fa_serial_pkg:
  - state typedef {ST_IDLE, ST_RUN, ST_DONE}, 2-bit encoding;
  - function computing CNT_W from WIDTH.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: REQ vector and pointer.
  - Outputs: one-hot winner and its index.
- The adder is one instance of the techlib FA cell; no other arithmetic is inferred.

Test Plan:
1. Reset behaviour: R_N low for 3 cycles, with REQ=1111 -> all outputs 0. After release, REQ=0000 for 5 cycles -> stays IDLE, BUSY=0.
2. Single add (NREQ=4, WIDTH=8): REQ=0001, A=0x5A, B=0x33, CI=0 -> ACK=0001 at t+1, DONE=0001 at t+9, SUM=0x8D, CO=0.
3. Carry paths:
   - client 2: A=0xFF, B=0x01, CI=0 -> SUM=0x00, CO=1;
   - then A=0xFF, B=0xFF, CI=1 -> SUM=0xFF, CO=1.
4. Fairness: REQ=1111 held throughout -> ACK order 0,1,2,3,0. Each DONE is 10 cycles apart, with the matching GNT.
5. Abort: R_N pulsed low 4 cycles into RUN -> no DONE, SUM=0. After release with REQ=0100 still high -> client 2 re-ACKed and completes correctly.
6. Overflow (with FA_SERIAL_OVF_EN): A=0x7F, B=0x01 -> SUM=0x80, CO=0, OVF=1; A=0x80, B=0x80 -> SUM=0x00, CO=1, OVF=1.

Source files
------------

// File: rtl/fa_serial_pkg.sv
// ============================================================================
// Module : fa_serial_pkg
// Brief  : Shared types and sizing helpers for fa_serial_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fa_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter carries one spare bit so reaching WIDTH never wraps.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// Module : fa_cell
// Brief  : Technology-library single-bit full adder cell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (A & CI) | (B & CI);

endmodule

`default_nettype wire

// File: rtl/fa_serial_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; the search starts at ptr+1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (i_req[j[IDX_W-1:0]]) begin
        o_idx   = j[IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/fa_serial_arbiter.sv
// ============================================================================
// Module : fa_serial_arbiter
// Brief  : Shares one bit-serial FA cell among NREQ round-robin requesters.
//          Optional OVF output enabled by defining FA_SERIAL_OVF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_serial_arbiter
  import fa_serial_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  C,
  input  logic                  R_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] A_IN,
  input  logic [NREQ*WIDTH-1:0] B_IN,
  input  logic [NREQ-1:0]       CI_IN,
  output logic [NREQ-1:0]       ACK,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic [WIDTH-1:0]      SUM,
  output logic                  CO,
`ifdef FA_SERIAL_OVF_EN
  output logic                  OVF,
`endif
  output logic                  BUSY
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = cnt_w(WIDTH);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_capture;
  logic               w_last;

  logic [NREQ-1:0]    w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-2:0]   r_sum_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [NREQ-1:0]    r_ack;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_co;

  logic               w_fa_s;
  logic               w_fa_co;
  logic [WIDTH-1:0]   w_sum_next;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req    (REQ),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  fa_cell u_fa (
    .A  (r_a_sr[0]),
    .B  (r_b_sr[0]),
    .CI (r_carry),
    .S  (w_fa_s),
    .CO (w_fa_co)
  );

  // Shift register plus the bit being produced this cycle forms the full sum.
  assign w_sum_next = {w_fa_s, r_sum_sr};

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_next_state = ST_RUN;
          w_capture    = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_next_state = ST_DONE;
          w_last       = 1'b1;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Results load on the final RUN edge so SUM/CO are valid alongside DONE.
  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      r_ptr    <= IDX_W'(NREQ - 1);
      r_owner  <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_sum    <= '0;
      r_co     <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      if (w_capture) begin
        r_a_sr  <= A_IN[w_pick_idx*WIDTH +: WIDTH];
        r_b_sr  <= B_IN[w_pick_idx*WIDTH +: WIDTH];
        r_carry <= CI_IN[w_pick_idx];
        r_cnt   <= '0;
        r_owner <= w_pick_idx;
        r_ack   <= w_pick_onehot;
        r_gnt   <= w_pick_onehot;
      end
      if (r_state == ST_RUN) begin
        r_a_sr   <= r_a_sr >> 1;
        r_b_sr   <= r_b_sr >> 1;
        r_sum_sr <= w_sum_next[WIDTH-1:1];
        r_carry  <= w_fa_co;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_co   <= w_fa_co;
        r_done <= r_gnt;
      end
      if (r_state == ST_DONE) begin
        r_gnt <= '0;
        r_ptr <= r_owner;
      end
    end
  end

`ifdef FA_SERIAL_OVF_EN
  logic r_ovf;

  // Carry into the MSB is the carry flop while the last bit is summed.
  always_ff @(posedge C or negedge R_N) begin
    if (!R_N)        r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_carry ^ w_fa_co;
  end

  assign OVF = r_ovf;
`endif

  assign ACK  = r_ack;
  assign GNT  = r_gnt;
  assign DONE = r_done;
  assign SUM  = r_sum;
  assign CO   = r_co;
  assign BUSY = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fa_serial_arbiter.sv
// ============================================================================
// Module : tb_fa_serial_arbiter
// Brief  : Scoreboard bench for fa_serial_arbiter (NREQ=4, WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fa_serial_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  C = 1'b0;
  logic                  R_N = 1'b0;
  logic [NREQ-1:0]       REQ = '0;
  logic [NREQ*WIDTH-1:0] A_IN = '0;
  logic [NREQ*WIDTH-1:0] B_IN = '0;
  logic [NREQ-1:0]       CI_IN = '0;
  logic [NREQ-1:0]       ACK;
  logic [NREQ-1:0]       GNT;
  logic [NREQ-1:0]       DONE;
  logic [WIDTH-1:0]      SUM;
  logic                  CO;
  logic                  BUSY;
`ifdef FA_SERIAL_OVF_EN
  logic                  OVF;
`endif

  fa_serial_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .C     (C),
    .R_N   (R_N),
    .REQ   (REQ),
    .A_IN  (A_IN),
    .B_IN  (B_IN),
    .CI_IN (CI_IN),
    .ACK   (ACK),
    .GNT   (GNT),
    .DONE  (DONE),
    .SUM   (SUM),
    .CO    (CO),
`ifdef FA_SERIAL_OVF_EN
    .OVF   (OVF),
`endif
    .BUSY  (BUSY)
  );

  always #5 C = ~C;

  typedef struct {
    int         client;
    logic [7:0] sum;
    logic       co;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];
  exp_t mon_e;
  int   mon_a;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge C) cyc <= cyc + 1;

  function automatic logic [31:0] onehot(input int cl);
    return 32'(1) << cl;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_operands(input int cl, input logic [7:0] a, input logic [7:0] b, input logic ci);
    A_IN[cl*WIDTH +: WIDTH] = a;
    B_IN[cl*WIDTH +: WIDTH] = b;
    CI_IN[cl] = ci;
  endtask

  task automatic push_exp(input int cl, input logic [7:0] s, input logic co, input logic ovf);
    exp_t e;
    e.client = cl;
    e.sum    = s;
    e.co     = co;
    e.ovf    = ovf;
    exp_q.push_back(e);
  endtask

  // Bounded wait for a DONE strobe; returns the cycle it was seen in.
  task automatic wait_done(output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge C);
      if (DONE != '0) begin
        ok = 1'b1;
        t  = cyc;
      end
    end
    if (!ok) check("done_timeout", 32'(0), 32'(1));
  endtask

  // Single client, DUT idle on entry: checks ACK/GNT timing and DONE latency.
  task automatic do_op(input int cl, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic eco, input logic eovf);
    set_operands(cl, a, b, ci);
    REQ = '0;
    REQ[cl] = 1'b1;
    push_exp(cl, es, eco, eovf);
    ack_q.push_back(cl);
    @(posedge C); #1;
    check("ack_latency", 32'(ACK), onehot(cl));
    check("gnt_at_ack", 32'(GNT), onehot(cl));
    check("busy_in_run", 32'(BUSY), 32'(1));
    REQ = '0;
    repeat (WIDTH - 1) @(posedge C);
    #1;
    check("done_not_early", 32'(DONE), 32'(0));
    @(posedge C); #1;
    check("done_latency", 32'(DONE), onehot(cl));
    @(posedge C); #1;
    check("idle_after_done", 32'(BUSY), 32'(0));
    check("gnt_released", 32'(GNT), 32'(0));
  endtask

  // Scoreboard monitor: every ACK and DONE the DUT presents is matched in order.
  always @(negedge C) begin
    if (R_N === 1'b1) begin
      if (DONE != '0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(DONE), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("done_owner", 32'(DONE), onehot(mon_e.client));
          check("gnt_with_done", 32'(GNT), onehot(mon_e.client));
          check("sum", 32'(SUM), 32'(mon_e.sum));
          check("co", 32'(CO), 32'(mon_e.co));
`ifdef FA_SERIAL_OVF_EN
          check("ovf", 32'(OVF), 32'(mon_e.ovf));
`endif
        end
      end
      if (ACK != '0) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 32'(ACK), 32'(0));
        end else begin
          mon_a = ack_q.pop_front();
          check("ack_order", 32'(ACK), onehot(mon_a));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t;
    int prev;

    // Reset held with all clients requesting.
    R_N = 1'b0;
    REQ = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge C); #1;
      check("rst_outputs", {ACK, GNT, DONE, SUM, CO, BUSY}, 32'(0));
    end
    REQ = '0;
    R_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge C); #1;
      check("idle_busy", 32'(BUSY), 32'(0));
      check("idle_ack", 32'(ACK), 32'(0));
    end

    // Single add and carry paths.
    do_op(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
    do_op(2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Fairness from a fresh pointer: order 0,1,2,3,0, DONEs WIDTH+2 apart.
    R_N = 1'b0;
    repeat (2) @(posedge C);
    #1;
    R_N = 1'b1;
    set_operands(0, 8'h11, 8'h22, 1'b0);
    set_operands(1, 8'h80, 8'h90, 1'b1);
    set_operands(2, 8'h0F, 8'hF0, 1'b1);
    set_operands(3, 8'h3C, 8'h0C, 1'b0);
    push_exp(0, 8'h33, 1'b0, 1'b0);
    push_exp(1, 8'h11, 1'b1, 1'b1);
    push_exp(2, 8'h00, 1'b1, 1'b0);
    push_exp(3, 8'h48, 1'b0, 1'b0);
    push_exp(0, 8'h33, 1'b0, 1'b0);
    ack_q.push_back(0);
    ack_q.push_back(1);
    ack_q.push_back(2);
    ack_q.push_back(3);
    ack_q.push_back(0);
    REQ = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_done(ok, t);
      if (ok && k > 0) check("done_spacing", 32'(t - prev), 32'(WIDTH + 2));
      prev = t;
    end
    REQ = '0;
    repeat (3) @(posedge C);
    #1;
    check("fair_idle", 32'(BUSY), 32'(0));

    // Abort mid-run, then the still-requesting client is served again.
    set_operands(2, 8'h12, 8'h34, 1'b1);
    REQ = 4'b0100;
    ack_q.push_back(2);
    @(posedge C); #1;
    check("abort_ack", 32'(ACK), 32'(4'b0100));
    repeat (4) @(posedge C);
    #1;
    R_N = 1'b0;
    #1;
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_gnt", 32'(GNT), 32'(0));
    repeat (4) @(posedge C);
    #1;
    check("abort_no_done", 32'(DONE), 32'(0));
    check("abort_sum", 32'(SUM), 32'(0));
    push_exp(2, 8'h47, 1'b0, 1'b0);
    ack_q.push_back(2);
    R_N = 1'b1;
    @(posedge C); #1;
    check("reack_client2", 32'(ACK), 32'(4'b0100));
    REQ = '0;
    wait_done(ok, t);
    @(posedge C); #1;
    @(posedge C); #1;

`ifdef FA_SERIAL_OVF_EN
    do_op(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
`endif

    repeat (3) @(posedge C);
    #1;
    check("exp_drained", 32'(exp_q.size()), 32'(0));
    check("ack_drained", 32'(ack_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
